// File: rtl/init_dma.sv
// Grid-init DMA: streams ROWS*COLS words from a source RAM to up to N_DST destination RAMs.
// One word per cycle, RD_LAT pipeline from read to write; abort or reset drops in-flight words.
module init_dma #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 1,
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int RD_LAT = 1,
  parameter int N_DST  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_fill_val,
  input  logic [N_DST-1:0]  i_dst_mask,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [N_DST-1:0]  o_wr_en,
  output logic              o_busy,
  output logic              o_done
);

  localparam int TOTAL = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [1:0] MODE_FILL = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_fill;
  logic [N_DST-1:0]    r_mask;
  logic [ADDR_W-1:0]   r_cnt;
  logic [RD_LAT-1:0]   r_vld;
  logic [ADDR_W-1:0]   r_addr_pipe [RD_LAT];

  logic                w_accept;
  logic                w_issue;
  logic                w_kill;
  logic                w_wr_vld;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_last_rd;
  logic                w_last_wr;

  assign w_accept  = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_issue   = (r_state == S_RUN);
  assign w_kill    = i_abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_wr_vld  = r_vld[RD_LAT-1];
  assign w_wr_addr = r_addr_pipe[RD_LAT-1];
  assign w_last_rd = (r_cnt == LAST_ADDR);
  assign w_last_wr = w_wr_vld && (w_wr_addr == LAST_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_fill  <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_vld   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= i_mode;
        r_fill <= i_fill_val;
        r_mask <= i_dst_mask;
        r_cnt  <= '0;
      end else if (w_issue && !w_last_rd) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Abort empties the slot pipeline so nothing already read reaches a destination.
      if (w_kill) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_issue;
        for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Address slots carry no reset; their valid bits gate every use.
  always_ff @(posedge i_clk) begin
    r_addr_pipe[0] <= r_cnt;
    for (int i = 1; i < RD_LAT; i++) r_addr_pipe[i] <= r_addr_pipe[i-1];
  end

  always_comb begin
    w_next    = r_state;
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_wr_addr = '0;
    o_wr_data = '0;
    o_wr_en   = '0;
    o_busy    = 1'b0;
    o_done    = 1'b0;

    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN: begin
        o_busy = 1'b1;
        if (i_abort)        w_next = S_IDLE;
        else if (w_last_rd) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (i_abort)        w_next = S_IDLE;
        else if (w_last_wr) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    if (w_issue) begin
      o_rd_en   = (r_mode != MODE_FILL);
      o_rd_addr = r_cnt;
    end

    // Write data comes straight from the source bus in the cycle it is valid.
    if (w_wr_vld) begin
      o_wr_addr = w_wr_addr;
      o_wr_en   = r_mask;
      case (r_mode)
        MODE_FILL: o_wr_data = r_fill;
        MODE_INV:  o_wr_data = ~i_rd_data;
        default:   o_wr_data = i_rd_data;
      endcase
    end
  end

endmodule

// File: doc/init_dma.md
INIT_DMA -- requirements
Module: init_dma

Interface
REQ-001 Parameter: ADDR_W, default 24, width of read and write addresses.
REQ-002 Parameter: DATA_W, default 1, bits per block word.
REQ-003 Parameter: ROWS, default 5, grid rows.
REQ-004 Parameter: COLS, default 5, blocks per row; TOTAL = ROWS*COLS words per transfer, 1 <= TOTAL <= 2^ADDR_W.
REQ-005 Parameter: RD_LAT, default 1, source RAM read latency in cycles, RD_LAT >= 1.
REQ-006 Parameter: N_DST, default 4, number of destination RAMs.
REQ-007 clk  in  1  global clock; one clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle request pulse, sampled only in IDLE.
REQ-010 abort  in  1  cancels an active transfer.
REQ-011 mode  in  2  00 COPY, 01 FILL, 10 INVERT, 11 treated as COPY.
REQ-012 fill_val  in  DATA_W  word written in FILL mode.
REQ-013 dst_mask  in  N_DST  bit i enables writes to destination i.
REQ-014 rd_addr  out  ADDR_W  source read address.
REQ-015 rd_en  out  1  source read strobe.
REQ-016 rd_data  in  DATA_W  source data, valid RD_LAT cycles after rd_en.
REQ-017 wr_addr  out  ADDR_W  shared destination write address.
REQ-018 wr_data  out  DATA_W  shared destination write data.
REQ-019 wr_en  out  N_DST  per-destination write strobe.
REQ-020 busy  out  1  high in RUN and DRAIN.
REQ-021 done  out  1  one-cycle pulse on successful completion.

Function
REQ-022 The states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-023 In IDLE, start=1 with abort=0 SHALL latch mode, fill_val and dst_mask, clear the read counter and enter RUN; the latched values SHALL hold for the whole transfer.
REQ-024 The block SHALL ignore start outside IDLE.
REQ-025 In RUN, the block SHALL issue one read per cycle: rd_en=1, rd_addr=0..TOTAL-1 in consecutive cycles; after address TOTAL-1 it SHALL enter DRAIN.
REQ-026 In FILL mode, rd_en SHALL stay 0, while address sequencing and timing SHALL be identical to COPY.
REQ-027 The block SHALL launch the write for the address read in cycle t in cycle t+RD_LAT, with wr_addr equal to that read address.
REQ-028 wr_data SHALL be rd_data (COPY), ~rd_data (INVERT) or latched fill_val (FILL).
REQ-029 wr_en[i] SHALL be 1 exactly when a write slot is valid and latched dst_mask[i]=1; otherwise 0.
REQ-030 Throughput SHALL be one word per cycle: start accepted at cycle 0 -> first read at cycle 1, last write at cycle TOTAL+RD_LAT.
REQ-031 DRAIN SHALL last until the final write has issued, then go to DONE; DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-032 dst_mask=0 SHALL still run the full transfer, with no write strobes and done pulsed.
REQ-033 abort=1 in RUN or DRAIN SHALL force rd_en=0 and wr_en=0 from the next cycle, discard in-flight reads, enter IDLE, and not pulse done.
REQ-034 abort in the same cycle as the final write SHALL cancel done; that write still occurs.
REQ-035 When start and abort are both high in IDLE, the block SHALL remain in IDLE.
REQ-036 Address counters SHALL be ADDR_W wide with no wrap within a transfer; the block SHALL restart at 0 on every new transfer.

Reset
REQ-037 rst=1 SHALL force IDLE and clear rd_addr, wr_addr, wr_data, rd_en, wr_en, busy, done and all latched fields to 0, in any state.
REQ-038 rst mid-transfer SHALL drop all in-flight writes immediately; no wr_en and no done SHALL follow.
REQ-039 After rst deasserts, the block SHALL accept start in the first cycle.

Verification
REQ-040 Defaults, COPY, dst_mask=1111, source word k = k[0]: start -> 25 writes, addresses 0..24, wr_en=1111 at cycles 2..26, done at cycle 27.
REQ-041 RD_LAT=3, INVERT, dst_mask=0101: start -> wr_data=~src, only wr_en[0] and wr_en[2] asserted, last write at cycle 28.
REQ-042 FILL, fill_val=1, dst_mask=0010: start -> rd_en never asserted, 25 writes of 1 to destination 1 only.
REQ-043 abort at cycle 10 of a COPY -> no wr_en from cycle 11 on, done never pulses, busy=0; a new start then completes normally from address 0.
REQ-044 start held high during a transfer, and rst at cycle 5 -> second start ignored while busy; reset clears all outputs next cycle with no further writes.
REQ-045 ROWS=1, COLS=1 with a start pulse -> exactly one write to address 0, done at cycle 1+RD_LAT+1.
